bsg_manycore_load_decoder: RTL and testbench

Synthesizable tile-side endpoint for the SPMD load protocol. It accepts remote-store packets from the host loader (icache fill, dmem fill, tile-group CSR config, freeze/unfreeze), classifies each packet by address, and drives the matching icache or dmem write port or config register. After every packet, including dropped ones, it returns a one-word acknowledge toward the packet's source. It sits between the tile's network input and its memories, and it holds the tile frozen until the unfreeze store arrives.

---
 rtl/bsg_manycore_load_decoder_pkg.sv | 30 +++
 rtl/bsg_manycore_load_addr_decode.sv | 55 +++++
 rtl/bsg_manycore_load_decoder.sv | 171 +++++++++++++++++
 tb/tb_bsg_manycore_load_decoder.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_manycore_load_decoder_pkg.sv
// Shared types for the tile-side SPMD load endpoint: FSM states, ack status,
// decoded region and config-space word offsets.
package bsg_manycore_load_decoder_pkg;

  typedef enum logic [1:0] {
    e_idle  = 2'd0,
    e_write = 2'd1,
    e_ack   = 2'd2
  } load_state_e;

  typedef enum logic [1:0] {
    e_status_ok        = 2'd0,
    e_status_drop_dest = 2'd1,
    e_status_drop_op   = 2'd2
  } load_status_e;

  typedef enum logic [1:0] {
    e_region_none   = 2'd0,
    e_region_config = 2'd1,
    e_region_icache = 2'd2,
    e_region_dmem   = 2'd3
  } load_region_e;

  localparam logic [1:0] op_remote_store_lp = 2'b01;

  localparam logic [1:0] cfg_freeze_offset_lp   = 2'd0;
  localparam logic [1:0] cfg_tg_org_x_offset_lp = 2'd1;
  localparam logic [1:0] cfg_tg_org_y_offset_lp = 2'd2;

endpackage

// File: rtl/bsg_manycore_load_addr_decode.sv
// Combinational classifier: maps a captured packet's destination, opcode and
// address to a target region plus the status reported back in the ack.
module bsg_manycore_load_addr_decode
  import bsg_manycore_load_decoder_pkg::*;
#(
  parameter int addr_width_p          = 30,
  parameter int x_cord_width_p        = -1,
  parameter int y_cord_width_p        = -1,
  parameter int epa_byte_addr_width_p = 16,
  parameter int icache_sel_bit_p      = -1,
  parameter int dmem_addr_width_p     = -1,
  parameter int mask_width_p          = 4
) (
  input  logic [addr_width_p-1:0]   addr,
  input  logic [1:0]                op,
  input  logic [mask_width_p-1:0]   op_ex,
  input  logic [x_cord_width_p-1:0] x_cord,
  input  logic [y_cord_width_p-1:0] y_cord,
  input  logic [x_cord_width_p-1:0] my_x,
  input  logic [y_cord_width_p-1:0] my_y,
  output load_region_e              region,
  output load_status_e              status
);

  localparam int cfg_bit_lp = epa_byte_addr_width_p - 3;

  logic dmem_hi;
  logic unused_addr;

  assign unused_addr = ^addr;

  always_comb begin
    region  = e_region_none;
    status  = e_status_ok;
    dmem_hi = 1'b0;
    // Bits between the dmem index and the config select must be clear for a dmem hit.
    for (int i = dmem_addr_width_p; i < cfg_bit_lp; i++) dmem_hi = dmem_hi | addr[i];

    if (x_cord != my_x || y_cord != my_y) begin
      status = e_status_drop_dest;
    end else if (op != op_remote_store_lp) begin
      status = e_status_drop_op;
    end else if (addr[cfg_bit_lp]) begin
      region = e_region_config;
      if (addr[1:0] == 2'd3) status = e_status_drop_op;
    end else if (addr[icache_sel_bit_p]) begin
      region = e_region_icache;
      if (op_ex != '1) status = e_status_drop_op;
    end else begin
      region = e_region_dmem;
      if (dmem_hi) status = e_status_drop_op;
    end
  end

endmodule

// File: rtl/bsg_manycore_load_decoder.sv
// Tile endpoint for host load stores: writes icache/dmem/config, then acks the source.
// Holds the tile frozen until the unfreeze config store commits.
module bsg_manycore_load_decoder
  import bsg_manycore_load_decoder_pkg::*;
#(
  parameter int data_width_p          = 32,
  parameter int addr_width_p          = 30,
  parameter int x_cord_width_p        = -1,
  parameter int y_cord_width_p        = -1,
  parameter int load_id_width_p       = 5,
  parameter int epa_byte_addr_width_p = 16,
  parameter int icache_sel_bit_p      = -1,
  parameter int icache_addr_width_p   = -1,
  parameter int dmem_addr_width_p     = -1,
  localparam int mask_width_lp   = data_width_p / 8,
  localparam int packet_width_lp = load_id_width_p + addr_width_p + 2 + mask_width_lp
                                   + data_width_p + 2 * (x_cord_width_p + y_cord_width_p),
  localparam int ack_width_lp    = 2 + x_cord_width_p + y_cord_width_p
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic [packet_width_lp-1:0]     data_i,
  input  logic                           v_i,
  output logic                           ready_o,
  input  logic [x_cord_width_p-1:0]      my_x_i,
  input  logic [y_cord_width_p-1:0]      my_y_i,
  output logic                           icache_v_o,
  output logic [icache_addr_width_p-1:0] icache_addr_o,
  output logic [data_width_p-1:0]        icache_data_o,
  input  logic                           icache_ready_i,
  output logic                           dmem_v_o,
  output logic [dmem_addr_width_p-1:0]   dmem_addr_o,
  output logic [data_width_p-1:0]        dmem_data_o,
  output logic [mask_width_lp-1:0]       dmem_mask_o,
  input  logic                           dmem_ready_i,
  output logic                           freeze_o,
  output logic [x_cord_width_p-1:0]      tg_org_x_o,
  output logic [y_cord_width_p-1:0]      tg_org_y_o,
  output logic                           ack_v_o,
  output logic [ack_width_lp-1:0]        ack_data_o,
  input  logic                           ack_ready_i,
  output logic [31:0]                    store_count_o,
  output logic                           error_o
);

  typedef struct packed {
    logic [load_id_width_p-1:0] load_id;
    logic [addr_width_p-1:0]    addr;
    logic [1:0]                 op;
    logic [mask_width_lp-1:0]   op_ex;
    logic [data_width_p-1:0]    payload;
    logic [y_cord_width_p-1:0]  src_y_cord;
    logic [x_cord_width_p-1:0]  src_x_cord;
    logic [y_cord_width_p-1:0]  y_cord;
    logic [x_cord_width_p-1:0]  x_cord;
  } packet_s;

  typedef struct packed {
    load_status_e              status;
    logic [y_cord_width_p-1:0] src_y;
    logic [x_cord_width_p-1:0] src_x;
  } ack_s;

  load_state_e               state_r;
  packet_s                   pkt_r;
  load_status_e              status_r;
  logic                      freeze_r;
  logic [x_cord_width_p-1:0] tg_org_x_r;
  logic [y_cord_width_p-1:0] tg_org_y_r;
  logic [31:0]               store_count_r;
  logic                      error_r;

  load_region_e region;
  load_status_e dec_status;
  logic         write_ok;
  logic         write_done;
  ack_s         ack;
  logic         unused_load_id;

  bsg_manycore_load_addr_decode #(
    .addr_width_p          (addr_width_p),
    .x_cord_width_p        (x_cord_width_p),
    .y_cord_width_p        (y_cord_width_p),
    .epa_byte_addr_width_p (epa_byte_addr_width_p),
    .icache_sel_bit_p      (icache_sel_bit_p),
    .dmem_addr_width_p     (dmem_addr_width_p),
    .mask_width_p          (mask_width_lp)
  ) decode (
    .addr   (pkt_r.addr),
    .op     (pkt_r.op),
    .op_ex  (pkt_r.op_ex),
    .x_cord (pkt_r.x_cord),
    .y_cord (pkt_r.y_cord),
    .my_x   (my_x_i),
    .my_y   (my_y_i),
    .region (region),
    .status (dec_status)
  );

  assign unused_load_id = ^pkt_r.load_id;

  // Strobes come only from registered state and pkt_r, so they hold steady across stalls.
  assign write_ok   = (state_r == e_write) && (dec_status == e_status_ok);
  assign write_done = (dec_status != e_status_ok) || (region == e_region_config)
                    || (region == e_region_icache && icache_ready_i)
                    || (region == e_region_dmem && dmem_ready_i);

  assign ready_o       = (state_r == e_idle);
  assign icache_v_o    = write_ok && (region == e_region_icache);
  assign icache_addr_o = pkt_r.addr[icache_addr_width_p-1:0];
  assign icache_data_o = pkt_r.payload;
  assign dmem_v_o      = write_ok && (region == e_region_dmem);
  assign dmem_addr_o   = pkt_r.addr[dmem_addr_width_p-1:0];
  assign dmem_data_o   = pkt_r.payload;
  assign dmem_mask_o   = pkt_r.op_ex;
  assign freeze_o      = freeze_r;
  assign tg_org_x_o    = tg_org_x_r;
  assign tg_org_y_o    = tg_org_y_r;
  assign store_count_o = store_count_r;
  assign error_o       = error_r;

  assign ack        = '{status: status_r, src_y: pkt_r.src_y_cord, src_x: pkt_r.src_x_cord};
  assign ack_v_o    = (state_r == e_ack);
  assign ack_data_o = ack;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r       <= e_idle;
      pkt_r         <= '0;
      status_r      <= e_status_ok;
      freeze_r      <= 1'b1;
      tg_org_x_r    <= '0;
      tg_org_y_r    <= '0;
      store_count_r <= '0;
      error_r       <= 1'b0;
    end else begin
      case (state_r)
        e_idle: begin
          if (v_i) begin
            pkt_r   <= data_i;
            state_r <= e_write;
          end
        end
        e_write: begin
          if (write_done) begin
            status_r <= dec_status;
            state_r  <= e_ack;
            if (dec_status == e_status_ok) begin
              if (store_count_r != '1) store_count_r <= store_count_r + 32'd1;
              if (region == e_region_config) begin
                case (pkt_r.addr[1:0])
                  cfg_freeze_offset_lp:   freeze_r   <= pkt_r.payload[0];
                  cfg_tg_org_x_offset_lp: tg_org_x_r <= pkt_r.payload[x_cord_width_p-1:0];
                  cfg_tg_org_y_offset_lp: tg_org_y_r <= pkt_r.payload[y_cord_width_p-1:0];
                  default: ;
                endcase
              end
            end else begin
              error_r <= 1'b1;
            end
          end
        end
        e_ack: begin
          if (ack_ready_i) state_r <= e_idle;
        end
        default: state_r <= e_idle;
      endcase
    end
  end

endmodule

// File: tb/tb_bsg_manycore_load_decoder.sv
// Directed self-checking bench for bsg_manycore_load_decoder with
// epa=16, icache_sel_bit=10, icache/dmem index width 10.
module tb_bsg_manycore_load_decoder;

  localparam int DW = 32, AW = 30, XW = 4, YW = 5, LW = 5, MW = DW / 8;
  localparam int PW = LW + AW + 2 + MW + DW + 2 * (XW + YW);
  localparam int ACKW = 2 + XW + YW;

  typedef struct packed {
    logic [LW-1:0] load_id;
    logic [AW-1:0] addr;
    logic [1:0]    op;
    logic [MW-1:0] op_ex;
    logic [DW-1:0] payload;
    logic [YW-1:0] src_y;
    logic [XW-1:0] src_x;
    logic [YW-1:0] y;
    logic [XW-1:0] x;
  } pkt_t;

  localparam logic [XW-1:0] MY_X  = 4'd2;
  localparam logic [YW-1:0] MY_Y  = 5'd3;
  localparam logic [XW-1:0] SRC_X = 4'd1;
  localparam logic [YW-1:0] SRC_Y = 5'd4;
  localparam logic [1:0]    ST    = 2'b01;

  logic            clk = 1'b0;
  logic            reset_i;
  logic [PW-1:0]   data_i;
  logic            v_i;
  logic            ready_o;
  logic [XW-1:0]   my_x_i;
  logic [YW-1:0]   my_y_i;
  logic            icache_v_o;
  logic [9:0]      icache_addr_o;
  logic [DW-1:0]   icache_data_o;
  logic            icache_ready_i;
  logic            dmem_v_o;
  logic [9:0]      dmem_addr_o;
  logic [DW-1:0]   dmem_data_o;
  logic [MW-1:0]   dmem_mask_o;
  logic            dmem_ready_i;
  logic            freeze_o;
  logic [XW-1:0]   tg_org_x_o;
  logic [YW-1:0]   tg_org_y_o;
  logic            ack_v_o;
  logic [ACKW-1:0] ack_data_o;
  logic            ack_ready_i;
  logic [31:0]     store_count_o;
  logic            error_o;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bsg_manycore_load_decoder #(
    .data_width_p(DW), .addr_width_p(AW), .x_cord_width_p(XW), .y_cord_width_p(YW),
    .load_id_width_p(LW), .epa_byte_addr_width_p(16), .icache_sel_bit_p(10),
    .icache_addr_width_p(10), .dmem_addr_width_p(10)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .data_i(data_i), .v_i(v_i), .ready_o(ready_o),
    .my_x_i(my_x_i), .my_y_i(my_y_i),
    .icache_v_o(icache_v_o), .icache_addr_o(icache_addr_o), .icache_data_o(icache_data_o),
    .icache_ready_i(icache_ready_i),
    .dmem_v_o(dmem_v_o), .dmem_addr_o(dmem_addr_o), .dmem_data_o(dmem_data_o),
    .dmem_mask_o(dmem_mask_o), .dmem_ready_i(dmem_ready_i),
    .freeze_o(freeze_o), .tg_org_x_o(tg_org_x_o), .tg_org_y_o(tg_org_y_o),
    .ack_v_o(ack_v_o), .ack_data_o(ack_data_o), .ack_ready_i(ack_ready_i),
    .store_count_o(store_count_o), .error_o(error_o)
  );

  function automatic pkt_t mk(input logic [AW-1:0] a, input logic [1:0] op, input logic [3:0] ex,
                              input logic [31:0] pl, input logic [XW-1:0] x);
    mk = '{load_id: 5'd7, addr: a, op: op, op_ex: ex, payload: pl,
           src_y: SRC_Y, src_x: SRC_X, y: MY_Y, x: x};
  endfunction

  task automatic do_reset();
    reset_i = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    reset_i = 1'b0;
  endtask

  // Presents one packet for one cycle; returns #1 into the WRITE cycle.
  task automatic send(input pkt_t p);
    data_i = p; v_i = 1'b1;
    @(posedge clk); #1;
    v_i = 1'b0;
  endtask

  // Bounded wait for the ack; returns what was seen and steps past the handshake.
  task automatic collect_ack(output logic seen, output logic [ACKW-1:0] dat);
    seen = 1'b0; dat = '0;
    for (int i = 0; i < 20; i++) begin
      if (ack_v_o) begin seen = 1'b1; dat = ack_data_o; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (ready_o !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", ready_o); end
    tests++; if (freeze_o !== 1'b1) begin fails++; $display("FAIL reset_freeze got %b want 1", freeze_o); end
    tests++; if (tg_org_x_o !== 4'd0 || tg_org_y_o !== 5'd0) begin fails++; $display("FAIL reset_tg got %0d/%0d want 0/0", tg_org_x_o, tg_org_y_o); end
    tests++; if (store_count_o !== 32'd0) begin fails++; $display("FAIL reset_count got %0d want 0", store_count_o); end
    tests++; if (error_o !== 1'b0) begin fails++; $display("FAIL reset_error got %b want 0", error_o); end
    tests++; if ({icache_v_o, dmem_v_o, ack_v_o} !== 3'b000) begin fails++; $display("FAIL reset_valids got %b want 000", {icache_v_o, dmem_v_o, ack_v_o}); end
  endtask

  task automatic test_config();
    logic seen; logic [ACKW-1:0] dat;
    send(mk(30'h2001, ST, 4'hF, 32'd3, MY_X));
    collect_ack(seen, dat);
    tests++; if (!seen || dat !== {2'd0, SRC_Y, SRC_X}) begin fails++; $display("FAIL cfg_ack_x seen %b data %h want %h", seen, dat, {2'd0, SRC_Y, SRC_X}); end
    send(mk(30'h2002, ST, 4'hF, 32'd2, MY_X));
    collect_ack(seen, dat);
    tests++; if (!seen || dat !== {2'd0, SRC_Y, SRC_X}) begin fails++; $display("FAIL cfg_ack_y seen %b data %h want %h", seen, dat, {2'd0, SRC_Y, SRC_X}); end
    tests++; if (tg_org_x_o !== 4'd3) begin fails++; $display("FAIL cfg_tg_x got %0d want 3", tg_org_x_o); end
    tests++; if (tg_org_y_o !== 5'd2) begin fails++; $display("FAIL cfg_tg_y got %0d want 2", tg_org_y_o); end
    tests++; if (store_count_o !== 32'd2 || freeze_o !== 1'b1) begin fails++; $display("FAIL cfg_count_freeze got %0d/%b want 2/1", store_count_o, freeze_o); end
  endtask

  task automatic test_unfreeze_timing();
    tests++; if (ready_o !== 1'b1) begin fails++; $display("FAIL unfrz_c0_ready got %b want 1", ready_o); end
    send(mk(30'h2000, ST, 4'hF, 32'd0, MY_X));
    tests++; if ({freeze_o, ack_v_o, ready_o} !== 3'b100) begin fails++; $display("FAIL unfrz_c1 freeze/ack/ready got %b want 100", {freeze_o, ack_v_o, ready_o}); end
    @(posedge clk); #1;
    tests++; if ({freeze_o, ack_v_o, ready_o} !== 3'b010) begin fails++; $display("FAIL unfrz_c2 freeze/ack/ready got %b want 010", {freeze_o, ack_v_o, ready_o}); end
    @(posedge clk); #1;
    tests++; if ({ack_v_o, ready_o} !== 2'b01) begin fails++; $display("FAIL unfrz_c3 ack/ready got %b want 01", {ack_v_o, ready_o}); end
    tests++; if (store_count_o !== 32'd3) begin fails++; $display("FAIL unfrz_count got %0d want 3", store_count_o); end
  endtask

  task automatic test_icache_stall();
    int vcnt, wcnt, acnt, bad;
    do_reset();
    vcnt = 0; wcnt = 0; acnt = 0; bad = 0;
    icache_ready_i = 1'b0;
    send(mk(30'h405, ST, 4'hF, 32'hDEADBEEF, MY_X));
    for (int c = 0; c < 8; c++) begin
      icache_ready_i = (c >= 4);
      if (icache_v_o) begin
        vcnt++;
        if (icache_addr_o !== 10'd5 || icache_data_o !== 32'hDEADBEEF) bad++;
        if (icache_ready_i) wcnt++;
      end
      if (ack_v_o) acnt++;
      @(posedge clk); #1;
    end
    tests++; if (vcnt != 5) begin fails++; $display("FAIL icache_v_cycles got %0d want 5", vcnt); end
    tests++; if (bad != 0) begin fails++; $display("FAIL icache_stable got %0d bad cycles want 0", bad); end
    tests++; if (wcnt != 1 || acnt != 1) begin fails++; $display("FAIL icache_writes_acks got %0d/%0d want 1/1", wcnt, acnt); end
    tests++; if (store_count_o !== 32'd1) begin fails++; $display("FAIL icache_count got %0d want 1", store_count_o); end
  endtask

  task automatic test_dmem();
    logic seen; logic [ACKW-1:0] dat;
    send(mk(30'h7, ST, 4'b0011, 32'h12345678, MY_X));
    tests++; if (dmem_v_o !== 1'b1 || icache_v_o !== 1'b0) begin fails++; $display("FAIL dmem_strobe got d%b i%b want d1 i0", dmem_v_o, icache_v_o); end
    tests++; if (dmem_addr_o !== 10'd7 || dmem_mask_o !== 4'b0011 || dmem_data_o !== 32'h12345678) begin fails++; $display("FAIL dmem_fields got %0d/%b/%h want 7/0011/12345678", dmem_addr_o, dmem_mask_o, dmem_data_o); end
    collect_ack(seen, dat);
    tests++; if (!seen || dat !== {2'd0, SRC_Y, SRC_X}) begin fails++; $display("FAIL dmem_ack seen %b data %h want %h", seen, dat, {2'd0, SRC_Y, SRC_X}); end
    tests++; if (store_count_o !== 32'd2) begin fails++; $display("FAIL dmem_count got %0d want 2", store_count_o); end
  endtask

  task automatic test_dest_drop();
    logic seen; logic [ACKW-1:0] dat;
    send(mk(30'h7, ST, 4'hF, 32'h55, MY_X + 4'd1));
    tests++; if ({icache_v_o, dmem_v_o} !== 2'b00) begin fails++; $display("FAIL dest_no_strobe got %b want 00", {icache_v_o, dmem_v_o}); end
    collect_ack(seen, dat);
    tests++; if (!seen || dat !== {2'd1, SRC_Y, SRC_X}) begin fails++; $display("FAIL dest_ack seen %b data %h want %h", seen, dat, {2'd1, SRC_Y, SRC_X}); end
    tests++; if (error_o !== 1'b1) begin fails++; $display("FAIL dest_error got %b want 1", error_o); end
    send(mk(30'h8, ST, 4'hF, 32'h66, MY_X));
    collect_ack(seen, dat);
    tests++; if (!seen || dat !== {2'd0, SRC_Y, SRC_X} || error_o !== 1'b1) begin fails++; $display("FAIL dest_sticky ack %h error %b want %h 1", dat, error_o, {2'd0, SRC_Y, SRC_X}); end
    tests++; if (store_count_o !== 32'd3) begin fails++; $display("FAIL dest_count got %0d want 3", store_count_o); end
  endtask

  task automatic test_op_drops();
    logic [AW-1:0] addrs[4] = '{30'h2003, 30'h405, 30'h1007, 30'h7};
    logic [1:0]    ops[4]   = '{ST, ST, ST, 2'b00};
    logic [3:0]    exs[4]   = '{4'hF, 4'h7, 4'hF, 4'hF};
    for (int k = 0; k < 4; k++) begin
      send(mk(addrs[k], ops[k], exs[k], 32'd0, MY_X));
      tests++; if ({icache_v_o, dmem_v_o} !== 2'b00) begin fails++; $display("FAIL opdrop%0d_strobe got %b want 00", k, {icache_v_o, dmem_v_o}); end
      @(posedge clk); #1;
      tests++; if (ack_v_o !== 1'b1 || ack_data_o !== {2'd2, SRC_Y, SRC_X}) begin fails++; $display("FAIL opdrop%0d_ack v %b data %h want 1 %h", k, ack_v_o, ack_data_o, {2'd2, SRC_Y, SRC_X}); end
      @(posedge clk); #1;
    end
    tests++; if (store_count_o !== 32'd3 || freeze_o !== 1'b1 || tg_org_x_o !== 4'd0) begin fails++; $display("FAIL opdrop_state count %0d freeze %b tgx %0d want 3 1 0", store_count_o, freeze_o, tg_org_x_o); end
  endtask

  task automatic test_reset_mid();
    int extra;
    dmem_ready_i = 1'b0;
    send(mk(30'h9, ST, 4'hF, 32'h77, MY_X));
    @(posedge clk); #1;
    tests++; if (dmem_v_o !== 1'b1) begin fails++; $display("FAIL rstmid_stall got %b want 1", dmem_v_o); end
    reset_i = 1'b1;
    @(posedge clk); #1;
    tests++; if ({ready_o, dmem_v_o, ack_v_o, freeze_o} !== 4'b1001) begin fails++; $display("FAIL rstmid_outputs got %b want 1001", {ready_o, dmem_v_o, ack_v_o, freeze_o}); end
    tests++; if (store_count_o !== 32'd0 || error_o !== 1'b0) begin fails++; $display("FAIL rstmid_counters got %0d/%b want 0/0", store_count_o, error_o); end
    reset_i = 1'b0; dmem_ready_i = 1'b1;
    @(posedge clk); #1;
    tests++; if (ready_o !== 1'b1) begin fails++; $display("FAIL rstmid_ready got %b want 1", ready_o); end
    extra = 0;
    for (int c = 0; c < 5; c++) begin
      if (ack_v_o || dmem_v_o) extra++;
      @(posedge clk); #1;
    end
    tests++; if (extra != 0) begin fails++; $display("FAIL rstmid_no_ack got %0d active cycles want 0", extra); end
  endtask

  initial begin
    reset_i = 1'b1; v_i = 1'b0; data_i = '0;
    my_x_i = MY_X; my_y_i = MY_Y;
    icache_ready_i = 1'b1; dmem_ready_i = 1'b1; ack_ready_i = 1'b1;
    test_reset();
    test_config();
    test_unfreeze_timing();
    test_icache_stall();
    test_dmem();
    test_dest_drop();
    test_op_drops();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout tests run %0d", tests);
    $fatal(1, "timeout");
  end

endmodule
